array_ctrl: RTL and testbench
=============================

Name: array_ctrl

Overview:
- Sequencer for the SIZE x SIZE output-stationary systolic MAC array.
- Fetches operand vectors from the external A/B operand buffers and injects them with the diagonal skew the array needs.
- Drives the array enables, then walks the array's result select and streams the SIZE*SIZE 32-bit results out over a valid/ready port.
- Sits between the command front end (start/done) and the array.

Parameters:
- SIZE, 4, array dimension; matrices are SIZE x SIZE, inner dimension SIZE.
- MAC_LAT, 1, cycles from operand arrival at a MAC to accumulator update.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a matrix multiply when idle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last result handshake
- op_rd_en  out  1  operand buffer read strobe
- op_addr  out  $clog2(SIZE)  inner index k
- a_col  in  SIZE x 8  A[i][k] for all i; valid one cycle after op_rd_en
- b_row  in  SIZE x 8  B[k][j] for all j; valid one cycle after op_rd_en
- a_in  out  SIZE x 8  skewed row feed to the array
- b_in  out  SIZE x 8  skewed column feed to the array
- mult_en, acc_en  out  1  array multiply / accumulate enables
- load_en  out  1  one-cycle accumulator clear
- select  out  $clog2(SIZE*SIZE)  array result mux select
- d_out  in  32  array result at select (combinational)
- res_valid  out  1  result valid
- res_ready  in  1  downstream ready
- res_data  out  32  result C[i][j]
- res_idx  out  $clog2(SIZE*SIZE)  i*SIZE+j
- res_last  out  1  marks idx SIZE*SIZE-1

Behaviour:
- FSM states: IDLE, CLEAR, FEED, FLUSH, READ, FIN.
- Reset: state IDLE. All outputs 0: busy, done, op_rd_en, op_addr, a_in, b_in, enables, select, res_*. Skew registers are zeroed.
- Reset mid-operation:
  - Abandon the current job in the same cycle.
  - No done pulse is produced.
  - Any partial result stream is dropped (res_valid=0 next cycle).
- IDLE:
  - start=1 -> CLEAR.
  - start in any other state is ignored.
- CLEAR:
  - One cycle; load_en=1, busy=1 -> FEED.
- FEED:
  - SIZE cycles; op_rd_en=1, op_addr=k for k=0..SIZE-1 -> FLUSH.
- Skew:
  - Operand lane i (a_col[i], b_row[i]) passes through an i-stage delay line: lane 0 feeds directly, lane SIZE-1 is delayed SIZE-1 cycles.
  - The delay-line input is the returned data in the cycle after each op_rd_en; otherwise it is 0.
  - This guarantees zeros outside the valid wavefront.
- Compute window:
  - mult_en=acc_en=1 for exactly 3*SIZE-2+MAC_LAT cycles.
  - The window starts the cycle after the first op_rd_en, spanning the end of FEED and all of FLUSH.
- FLUSH:
  - Lasts until the window ends; zeros are injected -> READ.
- READ:
  - select=rd_idx.
  - When res_valid=0 or res_ready=1: capture res_data<=d_out, res_idx<=rd_idx, res_last<=(rd_idx==SIZE*SIZE-1), set res_valid=1, rd_idx++.
  - While res_valid=1 and res_ready=0: res_data/res_idx/res_last are held stable and rd_idx does not advance.
  - After the final handshake (res_last=1 and res_ready=1): res_valid=0 -> FIN.
- FIN:
  - done=1 for one cycle, busy=0 next cycle -> IDLE.
- Arithmetic: the array does all accumulation; the controller only routes values and never truncates them.
- Latency, SIZE=4, MAC_LAT=1, res_ready tied high:
  - First res_valid appears 1+4+(3*4-2+1-3)+1 cycles after start (the -3 accounts for window overlap with FEED).
  - The 16 results stream back to back.
  - The bench checks with an exact cycle counter derived from this formula.

Decomposition:
- Package array_pkg:
  - state enum ctrl_state_t.
  - Localparams IDX_W=$clog2(SIZE*SIZE), K_W=$clog2(SIZE), COMPUTE_CYCLES=3*SIZE-2+MAC_LAT.
- Sub-module skew_line:
  - Parameterised DEPTH, 8-bit data, synchronous reset.
  - Zero-depth is a pass-through.
  - Instantiated 2*SIZE times via generate (A lanes and B lanes).

Test Plan:
- A=identity, B[i][j]=i*4+j, res_ready=1 -> 16 results with res_data equal to B in idx order 0..15. res_last only on idx 15; one done pulse.
- A and B all 0xFF -> every result 260100 (4*255*255); no overflow or sign extension.
- A all 1s, B all 2s, res_ready toggling 1-0-0-1 -> every result 8. Data and idx are held stable while stalled; no result is lost or duplicated.
- start pulsed again during FEED and during READ -> ignored; exactly 16 results and a single done.
- reset asserted mid-FLUSH, then a fresh start with A=B=identity -> the next stream is the identity (1 on idx 0, 5, 10, 15, else 0). No stale values from the aborted job.
- Two back-to-back jobs (second start the cycle after done) -> load_en clears accumulators, so second-job results are independent of the first.

Source files
------------

// File: rtl/array_pkg.sv
// rtl/array_pkg.sv - shared types and sizing for the systolic array sequencer
package array_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, READ, FIN} ctrl_state_t;

  localparam int SIZE_DEF = 4;
  localparam int MAC_LAT_DEF = 1;
  localparam int IDX_W = $clog2(SIZE_DEF * SIZE_DEF);
  localparam int K_W = $clog2(SIZE_DEF);
  localparam int COMPUTE_CYCLES = 3 * SIZE_DEF - 2 + MAC_LAT_DEF;

  // Last operand pair meets the far corner MAC after 3*SIZE-2 cycles, then MAC_LAT to land
  function automatic int compute_cycles(int size, int mac_lat);
    return 3 * size - 2 + mac_lat;
  endfunction

endpackage

// File: rtl/skew_line.sv
// rtl/skew_line.sv - fixed-depth 8-bit delay line used to skew one operand lane
module skew_line #(
  parameter int DEPTH = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl = clk ^ reset;
    assign dout = din;
  end else begin : g_delay
    logic [7:0] taps [DEPTH];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int s = 0; s < DEPTH; s++) taps[s] <= '0;
      end else begin
        taps[0] <= din;
        for (int s = 1; s < DEPTH; s++) taps[s] <= taps[s-1];
      end
    end

    assign dout = taps[DEPTH-1];
  end

endmodule

// File: rtl/array_ctrl.sv
// rtl/array_ctrl.sv - sequencer: operand fetch, skewed injection, compute window, result stream
module array_ctrl
  import array_pkg::*;
#(
  parameter int SIZE    = SIZE_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          op_rd_en,
  output logic [$clog2(SIZE)-1:0]       op_addr,
  input  logic [SIZE*8-1:0]             a_col,
  input  logic [SIZE*8-1:0]             b_row,
  output logic [SIZE*8-1:0]             a_in,
  output logic [SIZE*8-1:0]             b_in,
  output logic                          mult_en,
  output logic                          acc_en,
  output logic                          load_en,
  output logic [$clog2(SIZE*SIZE)-1:0]  select,
  input  logic [31:0]                   d_out,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [31:0]                   res_data,
  output logic [$clog2(SIZE*SIZE)-1:0]  res_idx,
  output logic                          res_last
);

  localparam int W_K     = $clog2(SIZE);
  localparam int W_IDX   = $clog2(SIZE * SIZE);
  localparam int WIN_CYC = compute_cycles(SIZE, MAC_LAT);
  localparam int W_WIN   = $clog2(WIN_CYC + 1);

  ctrl_state_t        state;
  logic               rd_q;
  logic               window;
  logic [W_WIN-1:0]   win_cnt;
  logic [W_IDX-1:0]   rd_idx;

  assign mult_en = window;
  assign acc_en  = window;
  assign select  = rd_idx;

  // Lane i is delayed i cycles; feeding zeros outside read returns keeps the wavefront clean
  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    logic [7:0] a_feed;
    logic [7:0] b_feed;

    assign a_feed = rd_q ? a_col[i*8 +: 8] : 8'd0;
    assign b_feed = rd_q ? b_row[i*8 +: 8] : 8'd0;

    skew_line #(.DEPTH(i)) u_skew_a (
      .clk   (clk),
      .reset (reset),
      .din   (a_feed),
      .dout  (a_in[i*8 +: 8])
    );

    skew_line #(.DEPTH(i)) u_skew_b (
      .clk   (clk),
      .reset (reset),
      .din   (b_feed),
      .dout  (b_in[i*8 +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      op_rd_en  <= 1'b0;
      op_addr   <= '0;
      load_en   <= 1'b0;
      window    <= 1'b0;
      win_cnt   <= '0;
      rd_q      <= 1'b0;
      rd_idx    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
      res_last  <= 1'b0;
    end else begin
      rd_q    <= op_rd_en;
      load_en <= 1'b0;
      done    <= 1'b0;

      if (window) begin
        if (win_cnt == '0) window <= 1'b0;
        else win_cnt <= win_cnt - W_WIN'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            load_en <= 1'b1;
            rd_idx  <= '0;
          end
        end
        CLEAR: begin
          state    <= FEED;
          op_rd_en <= 1'b1;
          op_addr  <= '0;
        end
        FEED: begin
          // First read's data lands next cycle, which is where the window opens
          if (op_addr == '0) begin
            window  <= 1'b1;
            win_cnt <= W_WIN'(WIN_CYC - 1);
          end
          if (op_addr == W_K'(SIZE - 1)) begin
            op_rd_en <= 1'b0;
            op_addr  <= '0;
            state    <= FLUSH;
          end else begin
            op_addr <= op_addr + W_K'(1);
          end
        end
        FLUSH: begin
          if (!window || win_cnt == '0) state <= READ;
        end
        READ: begin
          if (res_valid && res_last && res_ready) begin
            res_valid <= 1'b0;
            done      <= 1'b1;
            state     <= FIN;
          end else if (!res_valid || res_ready) begin
            res_data  <= d_out;
            res_idx   <= rd_idx;
            res_last  <= (rd_idx == W_IDX'(SIZE * SIZE - 1));
            res_valid <= 1'b1;
            rd_idx    <= rd_idx + W_IDX'(1);
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_array_ctrl.sv
// tb/tb_array_ctrl.sv - directed bench for array_ctrl with operand buffer and 4x4 MAC array models
module tb_array_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, op_rd_en, mult_en, acc_en, load_en;
  logic [1:0]  op_addr;
  logic [31:0] a_col = '0;
  logic [31:0] b_row = '0;
  logic [31:0] a_in, b_in;
  logic [3:0]  select;
  logic [31:0] d_out;
  logic        res_valid, res_last;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;
  logic [3:0]  res_idx;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] rdy_pat = 4'b1001;

  always #5 clk = ~clk;

  array_ctrl #(.SIZE(4), .MAC_LAT(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .op_rd_en  (op_rd_en),
    .op_addr   (op_addr),
    .a_col     (a_col),
    .b_row     (b_row),
    .a_in      (a_in),
    .b_in      (b_in),
    .mult_en   (mult_en),
    .acc_en    (acc_en),
    .load_en   (load_en),
    .select    (select),
    .d_out     (d_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_idx   (res_idx),
    .res_last  (res_last)
  );

  // Operand buffers and output-stationary array
  logic [7:0]  mat_a [4][4] = '{default: '0};
  logic [7:0]  mat_b [4][4] = '{default: '0};
  logic [7:0]  pa [4][4] = '{default: '0};
  logic [7:0]  pb [4][4] = '{default: '0};
  logic [7:0]  av [4][4];
  logic [7:0]  bv [4][4];
  logic [31:0] acc [4][4] = '{default: '0};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      av[i][0] = a_in[i*8 +: 8];
      bv[0][i] = b_in[i*8 +: 8];
      for (int j = 1; j < 4; j++) begin
        av[i][j] = pa[i][j-1];
        bv[j][i] = pb[j-1][i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (op_rd_en) begin
      for (int i = 0; i < 4; i++) begin
        a_col[i*8 +: 8] <= mat_a[i][op_addr];
        b_row[i*8 +: 8] <= mat_b[op_addr][i];
      end
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (load_en) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= '0;
        end else if (mult_en) begin
          pa[i][j] <= av[i][j];
          pb[i][j] <= bv[i][j];
          if (acc_en) acc[i][j] <= acc[i][j] + {24'd0, av[i][j]} * {24'd0, bv[i][j]};
        end
      end
    end
  end

  assign d_out = acc[select[3:2]][select[1:0]];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, expv);
    end
  endtask

  // kind: 0 = constant fill, 1 = identity, 2 = i*4+j
  task automatic set_mats(input int ak, input logic [7:0] aval, input int bk, input logic [7:0] bval);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        mat_a[i][j] = (ak == 0) ? aval : (ak == 1) ? ((i == j) ? 8'd1 : 8'd0) : 8'(i*4 + j);
        mat_b[i][j] = (bk == 0) ? bval : (bk == 1) ? ((i == j) ? 8'd1 : 8'd0) : 8'(i*4 + j);
      end
    end
  endtask

  // ek: 0 = every result ev, 1 = result equals idx, 2 = identity matrix
  function automatic logic [31:0] exp_res(input int ek, input logic [31:0] ev, input int idx);
    case (ek)
      0:       return ev;
      1:       return 32'(idx);
      default: return (idx % 5 == 0) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic run_job(input bit stall, input int ek, input logic [31:0] ev, input bit extra, input bit tail);
    int exp_idx, ndone, nwin, lat;
    bit hold_pend, fin;
    logic [31:0] hd;
    logic [3:0]  hi;
    exp_idx = 0; ndone = 0; nwin = 0; lat = -1;
    hold_pend = 0; fin = 0; hd = '0; hi = '0;
    @(negedge clk);
    start = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    chk("load_en_in_clear", load_en, 1);
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start = extra && (cyc == 2 || cyc == 16);
      if (mult_en) nwin++;
      if (res_valid && lat < 0) begin
        lat = cyc;
        chk("first_valid_latency", 32'(lat), 14);
      end
      if (hold_pend) begin
        chk("hold_valid", res_valid, 1);
        chk("hold_data", res_data, hd);
        chk("hold_idx", res_idx, hi);
      end
      res_ready = stall ? rdy_pat[cyc % 4] : 1'b1;
      if (res_valid && res_ready) begin
        chk("res_data", res_data, exp_res(ek, ev, exp_idx));
        chk("res_idx", res_idx, 32'(exp_idx));
        chk("res_last", res_last, (exp_idx == 15) ? 1 : 0);
        exp_idx++;
      end
      hold_pend = res_valid && !res_ready;
      hd = res_data;
      hi = res_idx;
      if (done) begin
        ndone++;
        fin = 1;
      end
    end
    start = 1'b0;
    if (tail) begin
      repeat (3) begin
        @(negedge clk);
        if (done) ndone++;
      end
      chk("busy_idle_after_done", busy, 0);
    end
    chk("result_count", 32'(exp_idx), 16);
    chk("done_pulses", 32'(ndone), 1);
    chk("window_len", 32'(nwin), 11);
  endtask

  typedef struct {
    int         ak;
    logic [7:0] av;
    int         bk;
    logic [7:0] bv;
    bit         stall;
    int         ek;
    logic [31:0] ev;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int nd;
    tbl[0] = '{ak: 1, av: 8'd0,   bk: 2, bv: 8'd0,   stall: 0, ek: 1, ev: 32'd0};
    tbl[1] = '{ak: 0, av: 8'hFF,  bk: 0, bv: 8'hFF,  stall: 0, ek: 0, ev: 32'd260100};
    tbl[2] = '{ak: 0, av: 8'd1,   bk: 0, bv: 8'd2,   stall: 1, ek: 0, ev: 32'd8};
    tbl[3] = '{ak: 1, av: 8'd0,   bk: 1, bv: 8'd0,   stall: 0, ek: 2, ev: 32'd0};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_op_rd_en", op_rd_en, 0);
    chk("rst_mult_en", mult_en, 0);
    chk("rst_load_en", load_en, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_select", select, 0);
    chk("rst_a_in", a_in, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int v = 0; v < 4; v++) begin
      set_mats(tbl[v].ak, tbl[v].av, tbl[v].bk, tbl[v].bv);
      run_job(tbl[v].stall, tbl[v].ek, tbl[v].ev, 1'b0, 1'b1);
    end

    // start pulses during FEED and READ must be ignored
    set_mats(1, 8'd0, 2, 8'd0);
    run_job(1'b0, 1, 32'd0, 1'b1, 1'b1);

    // abort mid-FLUSH, then a clean identity job
    set_mats(0, 8'hFF, 0, 8'hFF);
    nd = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("flush_window_active", mult_en, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_mult_en", mult_en, 0);
    chk("abort_a_in", a_in, 0);
    chk("abort_b_in", b_in, 0);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", 32'(nd), 0);
    set_mats(1, 8'd0, 1, 8'd0);
    run_job(1'b0, 2, 32'd0, 1'b0, 1'b1);

    // back-to-back jobs: second start in the cycle after done
    set_mats(0, 8'hFF, 0, 8'hFF);
    run_job(1'b0, 0, 32'd260100, 1'b0, 1'b0);
    set_mats(0, 8'd1, 0, 8'd2);
    run_job(1'b0, 0, 32'd8, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
